// File: rtl/mvm_param.sv
// mvm_param: streaming matrix-vector multiplier, y = A * x.
// A is M x N and x has N elements, all signed WIDTH-bit words. One shared
// multiply-accumulate unit handles one product per cycle, so a row takes N
// cycles. Stored A can be reused by later transactions that load only x.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any transaction in flight
//   s_valid    in   input word valid
//   s_ready    out  block accepts an input word (IDLE / LOAD_A / LOAD_X)
//   data_in    in   WIDTH signed input word: A row-major, then x
//   new_matrix in   sampled on the first word only: 1 = load A then x, 0 = x only
//   m_valid    out  result word valid
//   m_ready    in   consumer accepts the result word
//   data_out   out  OUT_WIDTH signed result y[k]
//   overflow   out  a wrapped add occurred while accumulating y[k]
module mvm_param #(
  parameter int WIDTH     = 8,
  parameter int M         = 3,
  parameter int N         = 3,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [WIDTH-1:0]     data_in,
  input  logic                        new_matrix,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        overflow
);

  localparam int MN = M * N;
  localparam int AW = (MN > 1) ? $clog2(MN) : 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;

  if (OUT_WIDTH < 2 * WIDTH) begin : g_width_chk
    $error("mvm_param: OUT_WIDTH must be at least 2*WIDTH");
  end

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_e;

  state_e                        state_q, state_d;
  logic                          loaded_q;
  logic [AW-1:0]                 a_idx_q;
  logic [XW-1:0]                 x_idx_q;
  logic [AW-1:0]                 mac_idx_q;
  logic [XW-1:0]                 col_q;
  logic [MW-1:0]                 row_q;
  logic [MW-1:0]                 k_q;

  logic signed [WIDTH-1:0]       a_mem [MN];
  logic signed [WIDTH-1:0]       x_mem [N];
  logic signed [OUT_WIDTH-1:0]   y_buf [M];
  logic [M-1:0]                  ovf_buf;
  logic signed [OUT_WIDTH-1:0]   acc_q;
  logic                          ovf_q;

  logic                          s_fire, m_fire, load_a_start;
  logic signed [2*WIDTH-1:0]     prod;
  logic signed [OUT_WIDTH-1:0]   prod_ext, acc_in, sum;
  logic                          ovf_row, col_last;

  // Two's-complement add overflow: like-signed operands, differently-signed sum.
  function automatic logic add_ovf(input logic signed [OUT_WIDTH-1:0] a,
                                   input logic signed [OUT_WIDTH-1:0] b,
                                   input logic signed [OUT_WIDTH-1:0] s);
    return (a[OUT_WIDTH-1] == b[OUT_WIDTH-1]) && (s[OUT_WIDTH-1] != a[OUT_WIDTH-1]);
  endfunction

  assign s_fire       = s_valid & s_ready;
  assign m_fire       = m_valid & m_ready;
  // A reuse request is honoured only once a complete A has been stored.
  assign load_a_start = new_matrix | ~loaded_q;

  // MAC datapath: the accumulator restarts at column 0 of every row.
  assign col_last = (col_q == XW'(N - 1));
  assign prod     = a_mem[mac_idx_q] * x_mem[col_q];
  assign prod_ext = OUT_WIDTH'(prod);
  assign acc_in   = (col_q == '0) ? '0 : acc_q;
  assign sum      = acc_in + prod_ext;
  assign ovf_row  = add_ovf(acc_in, prod_ext, sum) | ((col_q != '0) & ovf_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (s_fire) begin
          if (load_a_start) state_d = (MN == 1) ? LOAD_X : LOAD_A;
          else              state_d = (N == 1) ? COMPUTE : LOAD_X;
        end
      LOAD_A:  if (s_fire && a_idx_q == AW'(MN - 1)) state_d = LOAD_X;
      LOAD_X:  if (s_fire && x_idx_q == XW'(N - 1))  state_d = COMPUTE;
      COMPUTE: if (mac_idx_q == AW'(MN - 1))         state_d = OUTPUT;
      OUTPUT:  if (m_fire && k_q == MW'(M - 1))      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = ~reset & ((state_q == IDLE) | (state_q == LOAD_A) | (state_q == LOAD_X));
    m_valid  = (state_q == OUTPUT);
    data_out = m_valid ? y_buf[k_q] : '0;
    overflow = m_valid & ovf_buf[k_q];
  end

  // Control: counters and the matrix_loaded flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      loaded_q  <= 1'b0;
      a_idx_q   <= '0;
      x_idx_q   <= '0;
      mac_idx_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      k_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mac_idx_q <= '0;
          col_q     <= '0;
          row_q     <= '0;
          k_q       <= '0;
          if (s_fire) begin
            if (load_a_start) begin
              a_idx_q <= AW'(1);
              x_idx_q <= '0;
              if (MN == 1) loaded_q <= 1'b1;
            end else begin
              x_idx_q <= XW'(1);
            end
          end
        end
        LOAD_A:
          if (s_fire) begin
            a_idx_q <= a_idx_q + AW'(1);
            if (a_idx_q == AW'(MN - 1)) loaded_q <= 1'b1;
          end
        LOAD_X:
          if (s_fire) x_idx_q <= x_idx_q + XW'(1);
        COMPUTE: begin
          mac_idx_q <= mac_idx_q + AW'(1);
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + MW'(1);
          end else begin
            col_q <= col_q + XW'(1);
          end
        end
        OUTPUT:
          if (m_fire) k_q <= k_q + MW'(1);
        default: ;
      endcase
    end
  end

  // Data: operand storage, accumulator and output buffer (never reset).
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE:
        if (s_fire) begin
          if (load_a_start) a_mem[0] <= data_in;
          else              x_mem[0] <= data_in;
        end
      LOAD_A: if (s_fire) a_mem[a_idx_q] <= data_in;
      LOAD_X: if (s_fire) x_mem[x_idx_q] <= data_in;
      COMPUTE: begin
        acc_q <= sum;
        ovf_q <= ovf_row;
        if (col_last) begin
          y_buf[row_q]   <= sum;
          ovf_buf[row_q] <= ovf_row;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mvm_param.sv
module tb_mvm_param;
  localparam int W = 8, TM = 3, TN = 3, OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  s_valid, s_ready, new_matrix, m_valid, m_ready, overflow;
  logic signed [W-1:0]   data_in;
  logic signed [OW-1:0]  data_out;

  logic                  s_valid1, s_ready1, new_matrix1, m_valid1, m_ready1, overflow1;
  logic signed [3:0]     data_in1;
  logic signed [7:0]     data_out1;

  mvm_param #(.WIDTH(W), .M(TM), .N(TN), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .new_matrix(new_matrix), .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
    .overflow(overflow));

  mvm_param #(.WIDTH(4), .M(2), .N(4), .OUT_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid1), .s_ready(s_ready1), .data_in(data_in1),
    .new_matrix(new_matrix1), .m_valid(m_valid1), .m_ready(m_ready1), .data_out(data_out1),
    .overflow(overflow1));

  int cmp_cnt = 0, err_cnt = 0;

  int mdl_a [TM*TN];
  bit mdl_loaded = 1'b0;
  int exp_y [TM];
  bit exp_o [TM];
  int got_y [TM];
  bit got_o [TM];

  int a_def [TM*TN] = '{1, -8, 3, 9, -5, 11, -7, 8, -9};
  int x_def [TN]    = '{1, -22, 3};
  int x_reu [TN]    = '{10, 11, 12};
  int a_ovf [TM*TN] = '{127, 127, 127, 1, 2, 3, 127, 127, 127};
  int x_ovf [TN]    = '{127, 127, 127};
  int a_rnd [TM*TN];
  int x_rnd [TN];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum per step, range-checked, then wrapped to OW bits.
  function automatic void model_compute(input int a [TM*TN], input int x [TN],
                                        output int y [TM], output bit o [TM]);
    for (int i = 0; i < TM; i++) begin
      int acc = 0;
      bit ov = 1'b0;
      for (int j = 0; j < TN; j++) begin
        int s = acc + a[i*TN+j] * x[j];
        if (s > 32767 || s < -32768) ov = 1'b1;
        s = s & 32'hFFFF;
        if (s >= 32768) s = s - 65536;
        acc = s;
      end
      y[i] = acc;
      o[i] = ov;
    end
  endfunction

  task automatic send_word(input int w, input bit nm, input bit rnd, input string tag);
    int guard = 0;
    bit done = 1'b0;
    if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    data_in = W'(w);
    new_matrix = nm;
    while (!done && guard < 20) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    if (!done) chk({tag, " accept timeout"}, 0, 1);
    s_valid = 1'b0;
    data_in = 'x;
    new_matrix = 1'($urandom_range(0, 1));
  endtask

  task automatic recv(input bit rnd, input string tag);
    int k = 0, guard = 0;
    bit held_v = 1'b0;
    logic signed [OW-1:0] hy;
    logic ho;
    while (k < TM && guard < 200) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      chk({tag, " s_ready low"}, s_ready, 0);
      if (m_valid) begin
        if (held_v) begin
          chk({tag, " stall data"}, data_out, hy);
          chk({tag, " stall ovf"}, overflow, ho);
        end
        if (m_ready) begin
          got_y[k] = data_out;
          got_o[k] = overflow;
          chk($sformatf("%s y[%0d]", tag, k), data_out, exp_y[k]);
          chk($sformatf("%s ovf[%0d]", tag, k), overflow, exp_o[k]);
          k++;
          held_v = 1'b0;
        end else begin
          hy = data_out;
          ho = overflow;
          held_v = 1'b1;
        end
      end else begin
        chk({tag, " idle data_out"}, data_out, 0);
      end
      @(posedge clk); #1;
      guard++;
    end
    m_ready = 1'b0;
    chk({tag, " output count"}, k, TM);
    chk({tag, " m_valid falls"}, m_valid, 0);
  endtask

  task automatic run_txn(input bit nm, input int a [TM*TN], input int x [TN],
                         input bit rnd, input string tag);
    bit load_a = nm || !mdl_loaded;
    if (load_a) begin
      for (int i = 0; i < TM*TN; i++)
        send_word(a[i], (i == 0) ? nm : 1'($urandom_range(0, 1)), rnd, tag);
      mdl_a = a;
      mdl_loaded = 1'b1;
    end
    for (int j = 0; j < TN; j++)
      send_word(x[j], (j == 0 && !load_a) ? nm : 1'($urandom_range(0, 1)), rnd, tag);
    model_compute(mdl_a, x, exp_y, exp_o);
    recv(rnd, tag);
  endtask

  task automatic chk_dir(input string tag, input int y0, input int y1, input int y2,
                         input bit o0, input bit o1, input bit o2);
    chk({tag, " lit y0"}, got_y[0], y0);
    chk({tag, " lit y1"}, got_y[1], y1);
    chk({tag, " lit y2"}, got_y[2], y2);
    chk({tag, " lit o0"}, got_o[0], o0);
    chk({tag, " lit o1"}, got_o[1], o1);
    chk({tag, " lit o2"}, got_o[2], o2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_loaded = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1 [8];
    int k1, g1;
    bit ok1;
    a1 = '{1, 2, 3, 4, -1, -2, -3, -4};
    reset = 1'b1; s_valid = 1'b0; data_in = 'x; new_matrix = 1'b0; m_ready = 1'b0;
    s_valid1 = 1'b0; data_in1 = 'x; new_matrix1 = 1'b0; m_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset s_ready", s_ready, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset data_out", data_out, 0);
    chk("reset overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready after reset", s_ready, 1);
    @(posedge clk); #1;

    // Directed cases, no backpressure.
    run_txn(1'b1, a_def, x_def, 1'b0, "default");
    chk_dir("default", 186, 152, -210, 0, 0, 0);
    run_txn(1'b0, a_def, x_reu, 1'b0, "reuse");
    chk_dir("reuse", -42, 167, -90, 0, 0, 0);
    run_txn(1'b1, a_ovf, x_ovf, 1'b0, "ovf");
    chk_dir("ovf", -17149, 762, -17149, 1, 0, 1);

    // Same cases under random input gaps and random m_ready.
    run_txn(1'b1, a_def, x_def, 1'b1, "bp default");
    chk_dir("bp default", 186, 152, -210, 0, 0, 0);
    run_txn(1'b0, a_def, x_reu, 1'b1, "bp reuse");
    chk_dir("bp reuse", -42, 167, -90, 0, 0, 0);
    run_txn(1'b1, a_ovf, x_ovf, 1'b1, "bp ovf");
    chk_dir("bp ovf", -17149, 762, -17149, 1, 0, 1);

    // Random operands with random reuse requests.
    for (int t = 0; t < 6; t++) begin
      foreach (a_rnd[i]) a_rnd[i] = int'($urandom_range(0, 255)) - 128;
      foreach (x_rnd[i]) x_rnd[i] = int'($urandom_range(0, 255)) - 128;
      run_txn(1'($urandom_range(0, 1)), a_rnd, x_rnd, 1'b1, $sformatf("rand%0d", t));
    end

    // Reuse requested before any matrix was loaded.
    do_reset();
    run_txn(1'b0, a_def, x_def, 1'b0, "reuse before load");
    chk_dir("reuse before load", 186, 152, -210, 0, 0, 0);

    // Reset while computing aborts the transaction.
    for (int i = 0; i < TM*TN; i++) send_word(a_ovf[i], (i == 0), 1'b0, "abort");
    for (int j = 0; j < TN; j++) send_word(x_ovf[j], 1'b0, 1'b0, "abort");
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort m_valid in reset", m_valid, 0);
    chk("abort s_ready in reset", s_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_loaded = 1'b0;
    @(negedge clk);
    chk("abort s_ready after reset", s_ready, 1);
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort no output", m_valid, 0);
    end
    m_ready = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b1, a_def, x_def, 1'b0, "after abort");
    chk_dir("after abort", 186, 152, -210, 0, 0, 0);

    // Non-default geometry: M=2, N=4, WIDTH=4, OUT_WIDTH=8.
    for (int i = 0; i < 12; i++) begin
      s_valid1 = 1'b1;
      data_in1 = 4'((i < 8) ? a1[i] : 1);
      new_matrix1 = 1'b1;
      ok1 = 1'b0;
      g1 = 0;
      while (!ok1 && g1 < 20) begin
        @(negedge clk);
        if (s_ready1) ok1 = 1'b1;
        @(posedge clk); #1;
        g1++;
      end
      if (!ok1) chk("p2 accept timeout", 0, 1);
    end
    s_valid1 = 1'b0;
    data_in1 = 'x;
    m_ready1 = 1'b1;
    k1 = 0;
    g1 = 0;
    while (k1 < 2 && g1 < 50) begin
      @(negedge clk);
      if (m_valid1) begin
        chk($sformatf("p2 y[%0d]", k1), data_out1, (k1 == 0) ? 10 : -10);
        chk($sformatf("p2 ovf[%0d]", k1), overflow1, 0);
        k1++;
      end
      @(posedge clk); #1;
      g1++;
    end
    chk("p2 output count", k1, 2);
    chk("p2 m_valid falls", m_valid1, 0);
    m_ready1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
